// File: rtl/dma_timing_control_pkg.sv
// dmaRegConfigPkg: shared state, transfer-type and command-bit definitions for the DMA engine
package dmaRegConfigPkg;
  localparam int CHANNELS = 4;
  localparam int ADDRESSWIDTH = 16;
  localparam int CMD_DISABLE = 2;
  localparam int CMD_ROTATE = 4;
  localparam logic [1:0] VERIFY = 2'b00;
  localparam logic [1:0] WRITE = 2'b01;
  localparam logic [1:0] READ = 2'b10;
  localparam logic [1:0] PTR_RESET = 2'd3;
  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} dmaState_t;
  function automatic logic [CHANNELS-1:0] chOneHot(input logic [1:0] ch);
    return CHANNELS'(1) << ch;
  endfunction
endpackage

// File: rtl/dma_timing_control_if.sv
// dma_timing_control_if: bus-side request/hold handshake and strobes of the DMA engine
interface dma_timing_control_if;
  import dmaRegConfigPkg::*;
  logic [CHANNELS-1:0] DREQ, DACK;
  logic HLDA, EOP_N_IN, HRQ, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT, EOP_N_OUT;
  modport master(
    input DREQ, HLDA, EOP_N_IN,
    output HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT, EOP_N_OUT
  );
  modport slave(
    output DREQ, HLDA, EOP_N_IN,
    input HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT, EOP_N_OUT
  );
endinterface

// File: rtl/dma_timing_control_priority_resolver.sv
// dma_priority_resolver: picks the winning DREQ, fixed or rotating from the channel after ptr
module dma_priority_resolver
  import dmaRegConfigPkg::*;
(
  input  logic [CHANNELS-1:0] dreq,
  input  logic                rotate,
  input  logic [1:0]          ptr,
  output logic                grantValid,
  output logic [1:0]          grantCh
);
  logic [1:0] base;
  assign base = rotate ? ptr + 2'd1 : 2'd0;
  assign grantValid = |dreq;
  // scan from lowest priority upward so the last hit is the highest-priority request
  always_comb begin
    grantCh = base;
    for (int i = CHANNELS - 1; i >= 0; i--)
      if (dreq[base + 2'(i)]) grantCh = base + 2'(i);
  end
endmodule

// File: rtl/dma_timing_control.sv
// dma_timing_control: DREQ arbitration, HRQ/HLDA handshake and single-transfer S0..S4 sequencing
module dma_timing_control
  import dmaRegConfigPkg::*;
(
  input  logic                      CLK,
  input  logic                      RESET_N,
  dma_timing_control_if.master      bus,
  input  logic [7:0]                commandReg,
  input  logic [CHANNELS-1:0][5:0]  modeReg,
  input  logic [CHANNELS-1:0]       tcReached,
  output logic [1:0]                activeChannel,
  output logic                      programCondition,
  output logic                      loadAddr,
  output logic                      updateCurrentAddressReg,
  output logic                      updateCurrentWordCountReg,
  output logic                      intEOP
);
  dmaState_t state;
  logic [1:0] ch, ptr, grantCh, xfer;
  logic grantValid, extEop, isRead, isWrite;
  logic unused;
  dma_priority_resolver resolver (
    .dreq(bus.DREQ),
    .rotate(commandReg[CMD_ROTATE]),
    .ptr(ptr),
    .grantValid(grantValid),
    .grantCh(grantCh)
  );
  // the illegal type 11 behaves as verify
  assign xfer = (modeReg[ch][1:0] == 2'b11) ? VERIFY : modeReg[ch][1:0];
  assign isRead = xfer == READ;
  assign isWrite = xfer == WRITE;
  assign activeChannel = ch;
  assign unused = ^{commandReg[7:5], commandReg[3], commandReg[1:0], modeReg};
  // outputs are registered on the transition into the state they belong to
  always_ff @(posedge CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= SI;
      ch <= '0;
      ptr <= PTR_RESET;
      extEop <= 1'b0;
      bus.HRQ <= 1'b0;
      bus.DACK <= '0;
      bus.AEN <= 1'b0;
      bus.ADSTB <= 1'b0;
      bus.MEMR_N <= 1'b1;
      bus.MEMW_N <= 1'b1;
      bus.IOR_N_OUT <= 1'b1;
      bus.IOW_N_OUT <= 1'b1;
      bus.EOP_N_OUT <= 1'b1;
      programCondition <= 1'b1;
      loadAddr <= 1'b0;
      updateCurrentAddressReg <= 1'b0;
      updateCurrentWordCountReg <= 1'b0;
      intEOP <= 1'b0;
    end else begin
      bus.ADSTB <= 1'b0;
      bus.MEMR_N <= 1'b1;
      bus.MEMW_N <= 1'b1;
      bus.IOR_N_OUT <= 1'b1;
      bus.IOW_N_OUT <= 1'b1;
      bus.EOP_N_OUT <= 1'b1;
      programCondition <= 1'b0;
      loadAddr <= 1'b0;
      updateCurrentAddressReg <= 1'b0;
      updateCurrentWordCountReg <= 1'b0;
      intEOP <= 1'b0;
      case (state)
        SI: begin
          extEop <= 1'b0;
          if (!commandReg[CMD_DISABLE] && grantValid) begin
            state <= S0;
            ch <= grantCh;
            bus.HRQ <= 1'b1;
          end else programCondition <= 1'b1;
        end
        S0:
          if (bus.HLDA) begin
            state <= S1;
            bus.AEN <= 1'b1;
            bus.ADSTB <= 1'b1;
            bus.DACK <= chOneHot(ch);
            loadAddr <= 1'b1;
          end else if (!bus.DREQ[ch]) begin
            state <= SI;
            bus.HRQ <= 1'b0;
            programCondition <= 1'b1;
          end
        S1: begin
          state <= S2;
          extEop <= extEop | !bus.EOP_N_IN;
          bus.MEMR_N <= !isRead;
          bus.IOR_N_OUT <= !isWrite;
        end
        S2: begin
          state <= S3;
          extEop <= extEop | !bus.EOP_N_IN;
          bus.MEMR_N <= !isRead;
          bus.IOW_N_OUT <= !isRead;
          bus.IOR_N_OUT <= !isWrite;
          bus.MEMW_N <= !isWrite;
        end
        S3: begin
          state <= S4;
          ptr <= ch;
          updateCurrentAddressReg <= 1'b1;
          updateCurrentWordCountReg <= 1'b1;
          bus.EOP_N_OUT <= !tcReached[ch];
          intEOP <= tcReached[ch] | extEop | !bus.EOP_N_IN;
        end
        S4: begin
          state <= SI;
          bus.HRQ <= 1'b0;
          bus.DACK <= '0;
          bus.AEN <= 1'b0;
          programCondition <= 1'b1;
        end
        default: state <= SI;
      endcase
    end
endmodule

// File: tb/tb_dma_timing_control.sv
// tb_dma_timing_control: scoreboard bench; stimulus predicts each transfer, a monitor checks S1..S4
module tb_dma_timing_control;
  logic CLK, RESET_N;
  logic [7:0] commandReg;
  logic [3:0][5:0] modeReg;
  logic [3:0] tcReached;
  logic [1:0] activeChannel;
  logic programCondition, loadAddr, updA, updW, intEOP;
  logic [1:0] mPtr;
  int total = 0, bad = 0;
  typedef struct {
    logic [1:0] ch;
    logic [3:0] memr, memw, ior, iow, eop, intE;
  } exp_t;
  exp_t expQ[$];
  dma_timing_control_if bus();
  dma_timing_control dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus),
    .commandReg(commandReg),
    .modeReg(modeReg),
    .tcReached(tcReached),
    .activeChannel(activeChannel),
    .programCondition(programCondition),
    .loadAddr(loadAddr),
    .updateCurrentAddressReg(updA),
    .updateCurrentWordCountReg(updW),
    .intEOP(intEOP)
  );
  initial CLK = 0;
  always #5 CLK = ~CLK;
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  // reference arbitration: walk channels in priority order
  function automatic logic [1:0] pick(input logic [3:0] r, input logic rot, input logic [1:0] p);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = rot ? (int'(p) + k) % 4 : k - 1;
      if (r[c]) return 2'(c);
    end
    return 2'd0;
  endfunction
  task automatic predict(input logic [3:0] dreq, input logic rot, input logic ext);
    exp_t e;
    logic [1:0] w, t;
    logic rd, wr;
    w = pick(dreq, rot, mPtr);
    t = modeReg[w][1:0];
    rd = t == 2'b10;
    wr = t == 2'b01;
    e.ch = w;
    e.memr = rd ? 4'b0110 : 4'b0000;
    e.iow = rd ? 4'b0100 : 4'b0000;
    e.ior = wr ? 4'b0110 : 4'b0000;
    e.memw = wr ? 4'b0100 : 4'b0000;
    e.eop = tcReached[w] ? 4'b1000 : 4'b0000;
    e.intE = (tcReached[w] || ext) ? 4'b1000 : 4'b0000;
    expQ.push_back(e);
    mPtr = w;
  endtask
  task automatic checkResetVals(input string tag);
    check({tag, " hrq"}, bus.HRQ, 0);
    check({tag, " dack"}, bus.DACK, 0);
    check({tag, " aen/adstb"}, {bus.AEN, bus.ADSTB}, 0);
    check({tag, " bus strobes"}, {bus.MEMR_N, bus.MEMW_N, bus.IOR_N_OUT, bus.IOW_N_OUT, bus.EOP_N_OUT}, 5'h1f);
    check({tag, " channel"}, activeChannel, 0);
    check({tag, " programCondition"}, programCondition, 1);
    check({tag, " internal strobes"}, {loadAddr, updA, updW, intEOP}, 0);
  endtask
  // d: cycles HLDA is held off in S0; extAt: 1/2 pulses EOP_N_IN in S1/S2
  task automatic doTransfer(input logic [3:0] dreq, input logic rot, input int d, input int extAt, input logic hldaDrop);
    int n;
    n = 0;
    do begin @(negedge CLK); n++; end while (!programCondition && n < 50);
    check("idle before request", programCondition, 1);
    commandReg = rot ? 8'h10 : 8'h00;
    bus.DREQ = dreq;
    bus.HLDA = (d == 0);
    predict(dreq, rot, extAt != 0);
    @(negedge CLK);
    check("hrq in S0", {bus.HRQ, bus.DACK}, 5'b10000);
    for (int i = 1; i < d; i++) begin
      @(negedge CLK);
      check("hrq waiting for hlda", {bus.HRQ, bus.DACK}, 5'b10000);
    end
    bus.HLDA = 1;
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.DACK == 0 && n < 10);
    check("dack reached", bus.DACK != 0, 1);
    bus.DREQ = 0;
    if (hldaDrop) bus.HLDA = 0;
    if (extAt == 1) bus.EOP_N_IN = 0;
    @(negedge CLK);
    bus.EOP_N_IN = (extAt == 2) ? 1'b0 : 1'b1;
    @(negedge CLK);
    bus.EOP_N_IN = 1;
    repeat (2) @(negedge CLK);
    bus.HLDA = 0;
  endtask
  // monitor: every DACK burst is captured over four cycles and matched against the queue head
  initial begin
    exp_t e;
    logic [3:0] memr, memw, ior, iow, eop, ie, la, ads, ua, uw, hrq, aen;
    logic [7:0] chs;
    logic [15:0] dk;
    logic [3:0] oh;
    logic abort;
    forever begin
      @(negedge CLK);
      if (RESET_N && bus.DACK != 0) begin
        abort = 0;
        for (int k = 0; k < 4; k++) begin
          if (k > 0) @(negedge CLK);
          if (!RESET_N) abort = 1;
          memr[k] = !bus.MEMR_N;
          memw[k] = !bus.MEMW_N;
          ior[k] = !bus.IOR_N_OUT;
          iow[k] = !bus.IOW_N_OUT;
          eop[k] = !bus.EOP_N_OUT;
          ie[k] = intEOP;
          la[k] = loadAddr;
          ads[k] = bus.ADSTB;
          ua[k] = updA;
          uw[k] = updW;
          hrq[k] = bus.HRQ;
          aen[k] = bus.AEN;
          chs[2*k +: 2] = activeChannel;
          dk[4*k +: 4] = bus.DACK;
        end
        if (!abort) begin
          if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected transfer: got channel %0d, want none", chs[1:0]);
          end else begin
            e = expQ.pop_front();
            oh = 4'b0001 << e.ch;
            check("activeChannel S1..S4", chs, {4{e.ch}});
            check("dack S1..S4", dk, {4{oh}});
            check("memr low", memr, e.memr);
            check("memw low", memw, e.memw);
            check("ior low", ior, e.ior);
            check("iow low", iow, e.iow);
            check("eop out low", eop, e.eop);
            check("intEOP", ie, e.intE);
            check("loadAddr/adstb", {la, ads}, 8'b0001_0001);
            check("update strobes", {ua, uw}, 8'b1000_1000);
            check("hrq/aen held", {hrq, aen}, 8'hff);
          end
        end
      end
    end
  end
  initial begin
    int n, cnt;
    RESET_N = 0;
    commandReg = 0;
    modeReg = '0;
    tcReached = 0;
    bus.DREQ = 0;
    bus.HLDA = 0;
    bus.EOP_N_IN = 1;
    mPtr = 2'd3;
    repeat (2) @(negedge CLK);
    checkResetVals("reset");
    RESET_N = 1;
    @(negedge CLK);
    commandReg = 8'h10;
    for (int i = 0; i < 5; i++) predict(4'hf, 1'b1, 1'b0);
    bus.DREQ = 4'hf;
    bus.HLDA = 1;
    n = 0;
    cnt = 0;
    while (cnt < 5 && n < 100) begin
      @(negedge CLK);
      n++;
      if (updA) cnt++;
    end
    check("rotating transfer count", cnt, 5);
    bus.DREQ = 0;
    bus.HLDA = 0;
    doTransfer(4'b0110, 0, 0, 0, 0);
    doTransfer(4'b0100, 0, 0, 0, 0);
    modeReg[0] = 6'b000010;
    doTransfer(4'b0001, 0, 1, 0, 0);
    modeReg[2] = 6'b000001;
    doTransfer(4'b0100, 0, 2, 0, 1);
    modeReg[1] = 6'b000011;
    doTransfer(4'b0010, 0, 0, 0, 0);
    tcReached = 4'b0001;
    doTransfer(4'b0001, 0, 0, 0, 0);
    tcReached = 0;
    doTransfer(4'b0001, 0, 0, 2, 0);
    @(negedge CLK);
    bus.DREQ = 4'b0001;
    bus.HLDA = 0;
    commandReg = 0;
    @(negedge CLK);
    check("drop: hrq in S0", bus.HRQ, 1);
    bus.DREQ = 0;
    @(negedge CLK);
    check("drop: back to idle", {bus.HRQ, bus.DACK, programCondition}, 6'b000001);
    @(negedge CLK);
    check("drop: stays idle", {bus.HRQ, bus.DACK}, 0);
    commandReg = 8'h04;
    bus.DREQ = 4'hf;
    bus.HLDA = 1;
    repeat (3) begin
      @(negedge CLK);
      check("disabled: no request", {bus.HRQ, bus.DACK, programCondition}, 6'b000001);
    end
    bus.DREQ = 0;
    bus.HLDA = 0;
    commandReg = 0;
    doTransfer(4'b1111, 1, 0, 0, 0);
    modeReg = '0;
    modeReg[3] = 6'b000010;
    @(negedge CLK);
    bus.DREQ = 4'b1000;
    bus.HLDA = 1;
    @(negedge CLK);
    @(negedge CLK);
    check("pre-reset dack", bus.DACK, 4'b1000);
    @(negedge CLK);
    check("pre-reset memr in S2", bus.MEMR_N, 0);
    #2 RESET_N = 0;
    #1 checkResetVals("async reset");
    mPtr = 2'd3;
    @(negedge CLK);
    #2 RESET_N = 1;
    predict(4'b1000, 1'b0, 1'b0);
    @(negedge CLK);
    check("post-reset hrq", bus.HRQ, 1);
    n = 0;
    do begin @(negedge CLK); n++; end while (bus.DACK == 0 && n < 10);
    bus.DREQ = 0;
    repeat (4) @(negedge CLK);
    bus.HLDA = 0;
    for (int i = 0; i < 40; i++) begin
      modeReg = 24'($urandom);
      tcReached = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      doTransfer(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    repeat (5) @(negedge CLK);
    check("scoreboard drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
